// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential slice adder: slice width, FSM
// encoding and helpers that size the slice counter.
package seq_adder_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

  // A single-slice adder still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_32_bit_rca_8_bit.sv
// 8-bit ripple-carry slice shared by the sequential adder; purely
// combinational, one full adder per bit.
module RCA_8_bit
  import seq_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               c_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               c_o
);

  logic carry;

  // NOTE: blocking assignments here on purpose -- carry is a combinational
  // temporary that must update bit by bit within one evaluation.
  always_comb begin
    carry = c_i;
    s_o   = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/seq_adder_32_bit.sv
// Multi-cycle WIDTH-bit adder: one 8-bit slice per clock, LSB first, with a
// start/done handshake. Define SEQ_ADDER_OVERFLOW_EN to add a signed overflow output.
module seq_adder_32_bit
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SEQ_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = calc_idx_w(NSLICE);

  if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0) begin : g_width_check
    $error("seq_adder_32_bit: WIDTH must be a positive multiple of 8");
  end

  typedef logic [NSLICE-1:0][SLICE_W-1:0] slices_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  slices_t          x_q, x_d, y_q, y_d, psum_q, psum_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_c;
  logic               last_slice;

  assign slice_a    = x_q[k_q];
  assign slice_b    = y_q[k_q];
  assign last_slice = (k_q == IDX_W'(NSLICE - 1));

  RCA_8_bit u_rca (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (c_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // NOTE: every _d gets its hold value first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          c_d     = carry_in;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        psum_d[k_q] = slice_s;
        c_d         = slice_c;
        k_d         = k_q + IDX_W'(1);
        if (last_slice) begin
          sum_d   = psum_d;
          cout_d  = slice_c;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = ST_IDLE;
`ifdef SEQ_ADDER_OVERFLOW_EN
          // Carry into the MSB recovered from the MSB's own sum bit.
          ovf_d   = (slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_s[SLICE_W-1]) ^ slice_c;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand and partial-sum registers are flops, not a memory, so they
  // are reset along with the control state to give a fully defined restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_adder_32_bit.sv
// Self-checking bench for seq_adder_32_bit: directed corner cases plus random
// operands against a plain-arithmetic reference model.
module tb_seq_adder_32_bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] sum;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int failures = 0;

  // Reference state: the last completed result the outputs must hold.
  logic [31:0] m_sum = '0;
  logic        m_cout = 1'b0;

  seq_adder_32_bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SEQ_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] a, b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
  endfunction

  // Counts rising edges until done is seen (sampled 1 after the edge).
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic run_add(input string tag, input logic [31:0] a, b, input logic ci);
    logic [32:0] exp;
    int n;
    exp = ref_add(a, b, ci);
    @(negedge clk);
    x = a; y = b; carry_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = $urandom; y = $urandom; carry_in = 1'($urandom);
    check({tag, "_busy_after_start"}, busy, 1);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      check({tag, "_busy_run"}, busy, 1);
      check({tag, "_sum_held"}, sum, m_sum);
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, sum, exp[31:0]);
    check({tag, "_cout"}, carry_out, exp[32]);
    check({tag, "_busy_at_done"}, busy, 0);
    m_sum = exp[31:0];
    m_cout = exp[32];
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sum_after"}, sum, m_sum);
  endtask

  initial begin
    int n;
    logic [32:0] exp;

    // Reset with clock running, then idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_sum", sum, 0);
    check("idle_cout", carry_out, 0);

    // Directed arithmetic and full ripple.
    run_add("basic", 32'h1234_5678, 32'h1111_1111, 1'b0);
    run_add("ripple0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    run_add("ripple1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_add("slice_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0);

    // Random operands.
    for (int i = 0; i < 8; i++)
      run_add($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom));

    // start while busy is ignored.
    exp = ref_add(32'h0000_00FA, 32'h0000_0028, 1'b0);
    @(negedge clk);
    x = 32'h0000_00FA; y = 32'h0000_0028; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    x = 32'd1; y = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("busy_ignore_latency", n, 2);
    check("busy_ignore_sum", sum, exp[31:0]);
    check("busy_ignore_cout", carry_out, exp[32]);
    m_sum = exp[31:0]; m_cout = exp[32];

    // start held high: back-to-back runs, done every 5 cycles.
    exp = ref_add(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1);
    @(negedge clk);
    x = 32'hDEAD_BEEF; y = 32'h1357_9BDF; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    wait_done(n);
    check("held_first_latency", n, 4);
    check("held_first_sum", sum, exp[31:0]);
    for (int i = 0; i < 2; i++) begin
      wait_done(n);
      check($sformatf("held_period%0d", i), n, 5);
      check($sformatf("held_sum%0d", i), sum, exp[31:0]);
      check($sformatf("held_cout%0d", i), carry_out, exp[32]);
    end
    start = 1'b0;
    m_sum = exp[31:0]; m_cout = exp[32];
    @(posedge clk); #1;
    check("held_stop_busy", busy, 0);

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    x = 32'h8000_0000; y = 32'h8000_0000; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", carry_out, 0);
    m_sum = '0; m_cout = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_hold_done", done, 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("abort_no_late_done", done, 0);
    end
    check("abort_sum_zero", sum, 0);
    run_add("post_abort", 32'd100, 32'd150, 1'b1);
    check("post_abort_251", m_sum, 32'd251);

`ifdef SEQ_ADDER_OVERFLOW_EN
    run_add("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("ovf_pos_flag", overflow, 1);
    run_add("ovf_none", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("ovf_none_flag", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic [32:0] r;
      a = $urandom; b = $urandom;
      r = ref_add(a, b, 1'b0);
      run_add($sformatf("ovf_rand%0d", i), a, b, 1'b0);
      check($sformatf("ovf_rand_flag%0d", i), overflow,
            {63'd0, (a[31] == b[31]) && (r[31] != a[31])});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
